fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Y86-64 fetch stage wrapped around the combinational instruction memory. Owns the predicted-PC
//  register, drives pc into instruction memory, and splits split/align into icode/ifun/rA/rB/valC.
//  Computes valP and the predicted next PC, and loads the F->D pipeline register (D_*) that feeds decode.
//  Tracks a fetch-halt state so fetch stops after halt, an invalid opcode or an address error.
// PARAMETERS
//  RESET_PC  64'h0  PC loaded into F_predPC on reset
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous active-low reset
//  imem_pc      out  64  PC to instruction memory (comb.)
//  imem_split   in   8   byte at pc: {icode,ifun}
//  imem_align   in   72  bytes pc+1..pc+9, byte pc+1 in [7:0]
//  imem_error   in   1   instruction memory address error
//  F_stall      in   1   hold F_predPC
//  D_stall      in   1   hold D register
//  D_bubble     in   1   load nop bubble into D
//  redir_valid  in   1   mispredict/ret correction this cycle
//  redir_pc     in   64  corrected fetch PC
//  D_stat       out  3   0=BUB 1=AOK 2=HLT 3=ADR 4=INS
//  D_icode      out  4   instruction code
//  D_ifun       out  4   function code
//  D_rA, D_rB   out  4   register ids, F = none
//  D_valC       out  64  constant word
//  D_valP       out  64  fall-through PC
//  D_pc         out  64  PC of instruction held in D
//  f_halted     out  1   fetch is in HALT state
// BEHAVIOUR
//  - f_pc = redir_valid ? redir_pc : F_predPC; imem_pc = f_pc. The memory is combinational, so the
//    instruction is decoded in the same cycle and registered into D at the next edge (latency 1).
//  - icode/ifun = split[7:4]/[3:0]. If imem_error: icode=1, ifun=0, stat=ADR.
//  - Valid set: 0, 1, 2(ifun 0-6), 3, 4, 5, 6(ifun 0-3), 7(ifun 0-6), 8, 9, A, B (all others ifun=0).
//    Otherwise stat=INS. icode 0 gives HLT; anything else AOK.
//  - need_regids = icode in {2,3,4,5,6,A,B}. need_valC = icode in {3,4,5,7,8}.
//  - rA/rB = need_regids ? align[7:4]/align[3:0] : 4'hF.
//  - valC = !need_valC ? 0 : need_regids ? align[71:8] : align[63:0].
//  - valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit unsigned, wraps modulo 2^64.
//  - predPC = (icode==7 || icode==8) ? valC : valP.
//  - Reset: F_predPC=RESET_PC; state=RUN; D <= bubble. Reset wins over every other input, including mid-stall.
//  - Bubble: stat=BUB, icode=1, ifun=0, rA=rB=F, valC=valP=pc=0.
//  - FSM RUN: F_predPC <= predPC unless F_stall. Exception: F_stall && redir_valid loads redir_pc,
//    so the redirect is not lost.
//  - RUN->HALT when D actually loads an instruction with stat != AOK (not stalled, not bubbled).
//  - FSM HALT: F_predPC is frozen and D loads a bubble unless D_stall.
//  - HALT->RUN only on redir_valid (the halting instruction was speculative). In that cycle redir_pc is
//    fetched and loaded normally.
//  - D priority: rst > D_stall (hold) > D_bubble (bubble) > HALT without redirect (bubble) > load.
//    D_stall together with D_bubble: stall wins.
//  - f_halted = (state==HALT). It is registered and is 0 out of reset.
// TESTING
//  1. rst_n=0 for 2 clk -> imem_pc=0, D_stat=0, D_icode=1, D_rA=F, f_halted=0; rst_n=1 -> fetch from 0.
//  2. Bytes 30 F0 00 01 00.. at 0 (irmovq $0x100,%rax) -> D_icode=3, D_rA=F, D_rB=0, D_valC=0x100,
//     D_valP=0xA, imem_pc=0xA.
//  3. 70 40 00.. at 0xA (jmp 0x40) -> D_valP=0x13, imem_pc=0x40. Then redir_valid=1, redir_pc=0x13 ->
//     imem_pc=0x13 in the same cycle; next D_pc=0x13.
//  4. Byte C0 -> D_stat=4, f_halted=1, imem_pc frozen, D=bubble afterwards.
//     Then redir_valid with redir_pc=0 -> f_halted=0, fetch resumes.
//  5. imem_error=1 -> D_stat=3, D_icode=1. Byte 00 -> D_stat=2. Both set f_halted.
//  6. F_stall=D_stall=1 for 3 clk -> imem_pc and D_* unchanged. D_bubble=1 -> D_stat=0.
//     D_stall=D_bubble=1 -> hold. rst_n=0 during stall -> reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: predicted-PC register, instruction split/align decode,
// valP / next-PC prediction, F->D pipeline register and the fetch-halt FSM.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_pc,
    input  logic [7:0]  imem_split,
    input  logic [71:0] imem_align,
    input  logic        imem_error,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [63:0] D_pc,
    output logic        f_halted
);

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;

    logic [63:0] f_pc;
    logic [3:0]  f_icode, f_ifun;
    logic        instr_valid;
    logic [2:0]  f_stat;
    logic        need_regids, need_valc;
    logic [3:0]  f_ra, f_rb;
    logic [63:0] f_valc, f_valp, f_pred;
    logic        fetch_active;
    logic        d_load, d_clear;

    // Select fetch PC; a redirect overrides the prediction in the same cycle.
    always_comb begin
        f_pc    = redir_valid ? redir_pc : pred_pc_q;
        imem_pc = f_pc;
    end

    // Split the instruction byte and classify the opcode.
    always_comb begin
        if (imem_error) begin
            f_icode = ICODE_NOP;
            f_ifun  = 4'h0;
        end else begin
            f_icode = imem_split[7:4];
            f_ifun  = imem_split[3:0];
        end

        unique case (f_icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB: instr_valid = (f_ifun == 4'h0);
            4'h2, 4'h7:             instr_valid = (f_ifun <= 4'h6);
            4'h6:                   instr_valid = (f_ifun <= 4'h3);
            default:                instr_valid = 1'b0;
        endcase

        if (imem_error)           f_stat = STAT_ADR;
        else if (!instr_valid)    f_stat = STAT_INS;
        else if (f_icode == 4'h0) f_stat = STAT_HLT;
        else                      f_stat = STAT_AOK;
    end

    // Align register ids / constant word and compute fall-through and predicted PC.
    always_comb begin
        need_regids = f_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        need_valc   = f_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

        f_ra = need_regids ? imem_align[7:4] : REG_NONE;
        f_rb = need_regids ? imem_align[3:0] : REG_NONE;

        if (!need_valc)      f_valc = 64'd0;
        else if (need_regids) f_valc = imem_align[71:8];
        else                  f_valc = imem_align[63:0];

        // Wraps modulo 2^64 by construction.
        f_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        f_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valc : f_valp;
    end

    // Fetch FSM next state, predicted-PC update and D register control.
    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        d_load    = 1'b0;
        d_clear   = 1'b0;

        unique case (state_q)
            StRun:  fetch_active = 1'b1;
            StHalt: fetch_active = redir_valid;
            default: fetch_active = 1'b1;
        endcase

        if (fetch_active) begin
            state_d = StRun;
            // A stalled fetch still captures a redirect so it is not lost.
            if (!F_stall)         pred_pc_d = f_pred;
            else if (redir_valid) pred_pc_d = redir_pc;
        end

        if (!D_stall) begin
            if (D_bubble || !fetch_active) begin
                d_clear = 1'b1;
            end else begin
                d_load = 1'b1;
                if (f_stat != STAT_AOK) state_d = StHalt;
            end
        end
    end

    // FSM state and predicted-PC registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

    // F->D pipeline register: reset/bubble clear, load, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n || d_clear) begin
            D_stat  <= STAT_BUB;
            D_icode <= ICODE_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
            D_pc    <= 64'd0;
        end else if (d_load) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= f_valc;
            D_valP  <= f_valp;
            D_pc    <= f_pc;
        end
    end

    // Halt flag is the registered FSM state.
    always_comb f_halted = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_pc;
    logic [7:0]  imem_split;
    logic [71:0] imem_align;
    logic        imem_error;
    logic        F_stall, D_stall, D_bubble, redir_valid;
    logic [63:0] redir_pc;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP, D_pc;
    logic        f_halted;
    logic        err_force;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_split(imem_split),
        .imem_align(imem_align), .imem_error(imem_error), .F_stall(F_stall),
        .D_stall(D_stall), .D_bubble(D_bubble), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .D_pc(D_pc),
        .f_halted(f_halted)
    );

    // Instruction memory: 256 bytes, anything above is an address error.
    function automatic logic [71:0] align_at(input logic [63:0] pc);
        logic [71:0] a;
        logic [7:0]  adr;
        for (int i = 0; i < 9; i++) begin
            adr = pc[7:0] + 8'(i + 1);
            a[i*8 +: 8] = mem[adr];
        end
        return a;
    endfunction

    assign imem_split = mem[imem_pc[7:0]];
    assign imem_align = align_at(imem_pc);
    assign imem_error = err_force || (imem_pc[63:8] != 56'd0);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pc;
    } drec_t;

    localparam drec_t BUBBLE = '{stat: 3'd0, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                 valc: 64'd0, valp: 64'd0, pc: 64'd0};

    logic [63:0] m_pred;
    bit          m_halt;
    drec_t       m_d;

    function automatic drec_t decode(input logic [63:0] pc, input bit err,
                                     output logic [63:0] pred);
        drec_t r;
        int    max_ifun;
        bit    regs, cw;
        logic [7:0] b [0:9];
        for (int i = 0; i < 10; i++) b[i] = mem[8'(pc[7:0] + 8'(i))];
        r.pc = pc;
        if (err) begin
            r.icode = 4'h1;
            r.ifun  = 4'h0;
        end else begin
            r.icode = b[0][7:4];
            r.ifun  = b[0][3:0];
        end
        case (int'(r.icode))
            2, 7:    max_ifun = 6;
            6:       max_ifun = 3;
            12, 13, 14, 15: max_ifun = -1;
            default: max_ifun = 0;
        endcase
        if (err)                            r.stat = 3'd3;
        else if (int'(r.ifun) > max_ifun)   r.stat = 3'd4;
        else if (r.icode == 4'h0)           r.stat = 3'd2;
        else                                r.stat = 3'd1;
        regs = r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cw   = r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        r.ra = regs ? b[1][7:4] : 4'hF;
        r.rb = regs ? b[1][3:0] : 4'hF;
        r.valc = 64'd0;
        if (cw) begin
            for (int i = 0; i < 8; i++) r.valc[i*8 +: 8] = regs ? b[i+2] : b[i+1];
        end
        r.valp = pc + 64'(1 + (regs ? 1 : 0) + (cw ? 8 : 0));
        pred = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
        return r;
    endfunction

    function automatic logic [63:0] model_fpc();
        return redir_valid ? redir_pc : m_pred;
    endfunction

    // Advance one clock: compute model next state from current inputs, then clock.
    task automatic tick();
        logic [63:0] fpc, pred, n_pred;
        bit          active, n_halt;
        drec_t       dec, n_d;
        if (!rst_n) begin
            n_pred = 64'h0;
            n_halt = 0;
            n_d    = BUBBLE;
        end else begin
            fpc    = model_fpc();
            dec    = decode(fpc, err_force || (fpc[63:8] != 56'd0), pred);
            active = !m_halt || redir_valid;
            n_pred = m_pred;
            n_d    = m_d;
            n_halt = m_halt;
            if (active) begin
                n_halt = 0;
                if (!F_stall)         n_pred = pred;
                else if (redir_valid) n_pred = redir_pc;
            end
            if (!D_stall) begin
                if (D_bubble || !active) begin
                    n_d = BUBBLE;
                end else begin
                    n_d = dec;
                    if (dec.stat != 3'd1) n_halt = 1;
                end
            end
        end
        @(posedge clk);
        m_pred = n_pred;
        m_halt = n_halt;
        m_d    = n_d;
        @(negedge clk);
    endtask

    task automatic set_in(input bit f_s, input bit d_s, input bit d_b, input bit rv,
                          input logic [63:0] rp);
        F_stall = f_s; D_stall = d_s; D_bubble = d_b; redir_valid = rv; redir_pc = rp;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst_n = 0;
        set_in(1, 1, 1, 1, 64'h55);
        tick();
        set_in(0, 0, 0, 0, 64'h0);
        tick();
        n_checks++; if (imem_pc !== 64'h0) begin n_errors++; $display("FAIL reset_pc got=%h exp=0", imem_pc); end
        n_checks++; if (D_stat !== 3'd0) begin n_errors++; $display("FAIL reset_stat got=%0d exp=0", D_stat); end
        n_checks++; if (D_icode !== 4'h1) begin n_errors++; $display("FAIL reset_icode got=%h exp=1", D_icode); end
        n_checks++; if (D_rA !== 4'hF) begin n_errors++; $display("FAIL reset_rA got=%h exp=F", D_rA); end
        n_checks++; if (f_halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got=%b exp=0", f_halted); end
        rst_n = 1;
        #1;
        n_checks++; if (imem_pc !== 64'h0) begin n_errors++; $display("FAIL fetch_from_0 got=%h exp=0", imem_pc); end
    endtask

    task automatic test_irmovq();
        tick();
        n_checks++; if (D_icode !== 4'h3 || D_stat !== 3'd1) begin n_errors++;
            $display("FAIL irmovq_icode got=%h/%0d exp=3/1", D_icode, D_stat); end
        n_checks++; if (D_rA !== 4'hF || D_rB !== 4'h0) begin n_errors++;
            $display("FAIL irmovq_regs got=%h,%h exp=F,0", D_rA, D_rB); end
        n_checks++; if (D_valC !== 64'h100) begin n_errors++; $display("FAIL irmovq_valC got=%h exp=100", D_valC); end
        n_checks++; if (D_valP !== 64'hA) begin n_errors++; $display("FAIL irmovq_valP got=%h exp=A", D_valP); end
        n_checks++; if (imem_pc !== 64'hA) begin n_errors++; $display("FAIL irmovq_nextpc got=%h exp=A", imem_pc); end
    endtask

    task automatic test_jump_redirect();
        tick();
        n_checks++; if (D_icode !== 4'h7 || D_valP !== 64'h13) begin n_errors++;
            $display("FAIL jmp_valP got=%h/%h exp=7/13", D_icode, D_valP); end
        n_checks++; if (imem_pc !== 64'h40) begin n_errors++; $display("FAIL jmp_target got=%h exp=40", imem_pc); end
        set_in(0, 0, 0, 1, 64'h13);
        #1;
        n_checks++; if (imem_pc !== 64'h13) begin n_errors++; $display("FAIL redir_comb got=%h exp=13", imem_pc); end
        tick();
        set_in(0, 0, 0, 0, 64'h0);
        #1;
        n_checks++; if (D_pc !== 64'h13 || D_icode !== 4'h1) begin n_errors++;
            $display("FAIL redir_Dpc got=%h/%h exp=13/1", D_pc, D_icode); end
        n_checks++; if (imem_pc !== 64'h14) begin n_errors++; $display("FAIL redir_next got=%h exp=14", imem_pc); end
    endtask

    task automatic test_invalid_halt();
        tick();
        n_checks++; if (D_stat !== 3'd4 || f_halted !== 1'b1) begin n_errors++;
            $display("FAIL ins_stat got=%0d/%b exp=4/1", D_stat, f_halted); end
        tick();
        n_checks++; if (imem_pc !== 64'h15) begin n_errors++; $display("FAIL halt_frozen got=%h exp=15", imem_pc); end
        n_checks++; if (D_stat !== 3'd0 || D_icode !== 4'h1) begin n_errors++;
            $display("FAIL halt_bubble got=%0d/%h exp=0/1", D_stat, D_icode); end
        set_in(0, 0, 0, 1, 64'h0);
        tick();
        set_in(0, 0, 0, 0, 64'h0);
        #1;
        n_checks++; if (f_halted !== 1'b0 || D_icode !== 4'h3 || D_pc !== 64'h0) begin n_errors++;
            $display("FAIL resume got=%b/%h/%h exp=0/3/0", f_halted, D_icode, D_pc); end
        n_checks++; if (imem_pc !== 64'hA) begin n_errors++; $display("FAIL resume_pc got=%h exp=A", imem_pc); end
    endtask

    task automatic test_adr_hlt();
        err_force = 1;
        tick();
        err_force = 0;
        n_checks++; if (D_stat !== 3'd3 || D_icode !== 4'h1 || f_halted !== 1'b1) begin n_errors++;
            $display("FAIL adr got=%0d/%h/%b exp=3/1/1", D_stat, D_icode, f_halted); end
        set_in(0, 0, 0, 1, 64'h30);
        tick();
        n_checks++; if (D_stat !== 3'd2 || f_halted !== 1'b1 || D_pc !== 64'h30) begin n_errors++;
            $display("FAIL hlt got=%0d/%b/%h exp=2/1/30", D_stat, f_halted, D_pc); end
        // Address error at the top of the address space: valP wraps to 0.
        set_in(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        n_checks++; if (D_stat !== 3'd3 || D_valP !== 64'h0) begin n_errors++;
            $display("FAIL wrap got=%0d/%h exp=3/0", D_stat, D_valP); end
        set_in(0, 0, 0, 1, 64'h0);
        tick();
        set_in(0, 0, 0, 0, 64'h0);
        #1;
        n_checks++; if (f_halted !== 1'b0 || D_icode !== 4'h3 || imem_pc !== 64'hA) begin n_errors++;
            $display("FAIL adr_resume got=%b/%h/%h exp=0/3/A", f_halted, D_icode, imem_pc); end
    endtask

    task automatic test_stall_bubble();
        set_in(1, 1, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (imem_pc !== 64'hA || D_icode !== 4'h3 || D_valC !== 64'h100) begin n_errors++;
                $display("FAIL stall_hold%0d got=%h/%h/%h exp=A/3/100", i, imem_pc, D_icode, D_valC); end
        end
        set_in(1, 0, 1, 0, 64'h0);
        tick();
        n_checks++; if (D_stat !== 3'd0 || imem_pc !== 64'hA) begin n_errors++;
            $display("FAIL bubble got=%0d/%h exp=0/A", D_stat, imem_pc); end
        set_in(0, 0, 0, 0, 64'h0);
        tick();
        n_checks++; if (D_icode !== 4'h7 || imem_pc !== 64'h40) begin n_errors++;
            $display("FAIL after_bubble got=%h/%h exp=7/40", D_icode, imem_pc); end
        set_in(1, 1, 1, 0, 64'h0);
        tick();
        n_checks++; if (D_icode !== 4'h7 || D_stat !== 3'd1 || D_pc !== 64'hA) begin n_errors++;
            $display("FAIL stall_over_bubble got=%h/%0d/%h exp=7/1/A", D_icode, D_stat, D_pc); end
        rst_n = 0;
        tick();
        n_checks++; if (D_stat !== 3'd0 || D_icode !== 4'h1 || imem_pc !== 64'h0 || f_halted !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_stall got=%0d/%h/%h/%b exp=0/1/0/0", D_stat, D_icode, imem_pc, f_halted);
        end
        rst_n = 1;
        set_in(0, 0, 0, 0, 64'h0);
    endtask

    // ---------------- randomized test against the model ----------------
    task automatic test_random();
        int          op;
        logic [63:0] exp_pc;
        for (int a = 0; a < 256; a++) begin
            op = int'($urandom_range(0, 99));
            if (op < 75) begin
                case ($urandom_range(0, 11))
                    2, 7:    mem[a] = {4'($urandom_range(2, 2) == 2 && ($urandom & 1) ? 2 : 7),
                                       4'($urandom_range(0, 6))};
                    6:       mem[a] = {4'h6, 4'($urandom_range(0, 3))};
                    0:       mem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h10;
                    default: mem[a] = {4'($urandom_range(1, 11)), 4'h0};
                endcase
            end else begin
                mem[a] = 8'($urandom);
            end
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n     = ($urandom_range(0, 99) >= 2);
            err_force = ($urandom_range(0, 99) < 5);
            F_stall   = ($urandom_range(0, 99) < 20);
            D_stall   = ($urandom_range(0, 99) < 15);
            D_bubble  = ($urandom_range(0, 99) < 10);
            redir_valid = ($urandom_range(0, 99) < 15);
            redir_pc  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, 255));
            #1;
            exp_pc = model_fpc();
            n_checks++; if (imem_pc !== exp_pc) begin n_errors++;
                $display("FAIL rnd_imem_pc cyc=%0d got=%h exp=%h", cyc, imem_pc, exp_pc); end
            tick();
            n_checks++;
            if ({D_stat, D_icode, D_ifun, D_rA, D_rB} !== {m_d.stat, m_d.icode, m_d.ifun, m_d.ra, m_d.rb}) begin
                n_errors++;
                $display("FAIL rnd_dfields cyc=%0d got=%0d/%h/%h/%h/%h exp=%0d/%h/%h/%h/%h", cyc, D_stat,
                         D_icode, D_ifun, D_rA, D_rB, m_d.stat, m_d.icode, m_d.ifun, m_d.ra, m_d.rb);
            end
            n_checks++;
            if ({D_valC, D_valP, D_pc} !== {m_d.valc, m_d.valp, m_d.pc}) begin
                n_errors++;
                $display("FAIL rnd_dwords cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, D_valC, D_valP, D_pc,
                         m_d.valc, m_d.valp, m_d.pc);
            end
            n_checks++; if (f_halted !== m_halt) begin n_errors++;
                $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", cyc, f_halted, m_halt); end
        end
        rst_n = 1;
        set_in(0, 0, 0, 0, 64'h0);
        err_force = 0;
    endtask

    initial begin
        m_pred = 64'h0;
        m_halt = 0;
        m_d    = BUBBLE;
        err_force = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h10;
        // irmovq $0x100,%rax at 0
        mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'h00; mem[3] = 8'h01;
        for (int a = 4; a < 10; a++) mem[a] = 8'h00;
        // jmp 0x40 at 0xA
        mem[8'h0A] = 8'h70; mem[8'h0B] = 8'h40;
        for (int a = 8'h0C; a < 8'h13; a++) mem[a] = 8'h00;
        mem[8'h13] = 8'h10;
        mem[8'h14] = 8'hC0;
        mem[8'h30] = 8'h00;
        mem[8'h40] = 8'hC0;
        @(negedge clk);
        test_reset();
        test_irmovq();
        test_jump_redirect();
        test_invalid_halt();
        test_adr_hlt();
        test_stall_bubble();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
